// File: rtl/epb_master_if.sv
// EPB initiator bundle: request/response side plus the EPB pins.
// The master modport is the epb_master view; slave is the requester/bus-model view.
interface epb_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [22:0] req_addr;
   logic [5:0]  req_addr_gp;
   logic [1:0]  req_be;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_timeout;
   logic        epb_cs_n;
   logic        epb_oe_n;
   logic        epb_r_w_n;
   logic [1:0]  epb_be_n;
   logic [22:0] epb_addr;
   logic [5:0]  epb_addr_gp;
   logic [15:0] epb_data_out;
   logic        epb_data_oe_n;
   logic [15:0] epb_data_in;
   logic        epb_rdy;
   logic [2:0]  state_dbg;

   modport master (
      input  req_valid, req_wr, req_addr, req_addr_gp, req_be, req_wdata,
      input  epb_data_in, epb_rdy,
      output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
      output epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_addr, epb_addr_gp,
      output epb_data_out, epb_data_oe_n, state_dbg
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_addr_gp, req_be, req_wdata,
      output epb_data_in, epb_rdy,
      input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
      input  epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_addr, epb_addr_gp,
      input  epb_data_out, epb_data_oe_n, state_dbg
   );
endinterface

// File: rtl/epb_master.sv
// EPB initiator: turns one outstanding request into an EPB read/write cycle
// with setup/strobe/hold sequencing, rdy wait and timeout.
module epb_master #(
   parameter int SETUP_CYCLES   = 1,
   parameter int HOLD_CYCLES    = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         epb_clk,
   input  logic         epb_rst_n,
   epb_master_if.master bus
);
   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // rsp_valid is a single-cycle pulse with no back-pressure.

   generate
      if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || HOLD_CYCLES < 1 || HOLD_CYCLES > 15 ||
          TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
         $error("epb_master: SETUP/HOLD/TIMEOUT parameter out of range");
      end
   endgenerate

   localparam logic [15:0] SETUP_LOAD   = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] HOLD_LOAD    = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_wr;
   logic        r_timeout;
   logic [15:0] r_rdata;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [15:0] r_rsp_rdata;
   logic        r_rsp_timeout;
   logic        r_cs_n;
   logic        r_oe_n;
   logic        r_r_w_n;
   logic [1:0]  r_be_n;
   logic [22:0] r_addr;
   logic [5:0]  r_addr_gp;
   logic [15:0] r_data_out;
   logic        r_data_oe_n;

   // One counter serves setup, timeout and hold since they never overlap.
   always_ff @(posedge epb_clk or negedge epb_rst_n) begin
      if (!epb_rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_wr          <= 1'b0;
         r_timeout     <= 1'b0;
         r_rdata       <= '0;
         r_req_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_timeout <= 1'b0;
         r_cs_n        <= 1'b1;
         r_oe_n        <= 1'b1;
         r_r_w_n       <= 1'b1;
         r_be_n        <= 2'b11;
         r_addr        <= '0;
         r_addr_gp     <= '0;
         r_data_out    <= '0;
         r_data_oe_n   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_req_ready <= 1'b1;
               if (bus.req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_wr        <= bus.req_wr;
                  r_timeout   <= 1'b0;
                  r_addr      <= bus.req_addr;
                  r_addr_gp   <= bus.req_addr_gp;
                  r_be_n      <= ~bus.req_be;
                  r_r_w_n     <= ~bus.req_wr;
                  if (bus.req_wr) begin
                     r_data_out  <= bus.req_wdata;
                     r_data_oe_n <= 1'b0;
                  end
                  r_cnt   <= SETUP_LOAD;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == 16'd0) begin
                  r_cs_n  <= 1'b0;
                  r_oe_n  <= r_wr;
                  r_cnt   <= TIMEOUT_LOAD;
                  r_state <= S_STROBE;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            S_STROBE: begin
               if (bus.epb_rdy || r_cnt == 16'd1) begin
                  if (bus.epb_rdy && !r_wr) r_rdata <= bus.epb_data_in;
                  r_timeout <= !bus.epb_rdy;
                  r_cs_n    <= 1'b1;
                  r_oe_n    <= 1'b1;
                  r_cnt     <= HOLD_LOAD;
                  r_state   <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            S_HOLD: begin
               if (r_cnt == 16'd0) begin
                  r_data_oe_n   <= 1'b1;
                  r_r_w_n       <= 1'b1;
                  r_be_n        <= 2'b11;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= (!r_wr && !r_timeout) ? r_rdata : 16'd0;
                  r_rsp_timeout <= r_timeout;
                  r_state       <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            S_RESP: begin
               r_rsp_valid   <= 1'b0;
               r_rsp_rdata   <= '0;
               r_rsp_timeout <= 1'b0;
               r_req_ready   <= 1'b1;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready     = r_req_ready;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_rdata     = r_rsp_rdata;
   assign bus.rsp_timeout   = r_rsp_timeout;
   assign bus.epb_cs_n      = r_cs_n;
   assign bus.epb_oe_n      = r_oe_n;
   assign bus.epb_r_w_n     = r_r_w_n;
   assign bus.epb_be_n      = r_be_n;
   assign bus.epb_addr      = r_addr;
   assign bus.epb_addr_gp   = r_addr_gp;
   assign bus.epb_data_out  = r_data_out;
   assign bus.epb_data_oe_n = r_data_oe_n;
   assign bus.state_dbg     = r_state;
endmodule

// File: tb/tb_epb_master.sv
// Directed bench for epb_master (TIMEOUT_CYCLES=8); outputs sampled on the falling edge.
module tb_epb_master;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;

  // cs_n high-run tracker for strobe spacing
  int   cs_high_run;
  int   last_gap;

  // per-transaction observations filled by watch_txn
  int          w_lat, w_cs_low, w_oe_low, w_doe_low, w_rw0, w_be_match, w_viol;
  logic [15:0] w_rdata;
  logic        w_to;

  epb_master_if bus ();

  epb_master #(
    .SETUP_CYCLES  (1),
    .HOLD_CYCLES   (1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .epb_clk  (clk),
    .epb_rst_n(rst_n),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (bus.epb_cs_n) cs_high_run <= cs_high_run + 1;
    else begin
      if (cs_high_run != 0) last_gap <= cs_high_run;
      cs_high_run <= 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for acceptance; returns in the first cycle after accept.
  task automatic issue(input logic wr, input logic [22:0] addr, input logic [5:0] gp,
                       input logic [1:0] be, input logic [15:0] wdata, input logic keep_valid);
    bus.req_valid   = 1'b1;
    bus.req_wr      = wr;
    bus.req_addr    = addr;
    bus.req_addr_gp = gp;
    bus.req_be      = be;
    bus.req_wdata   = wdata;
    for (int i = 0; i < 20 && !bus.req_ready; i++) step();
    chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    step();
    if (!keep_valid) bus.req_valid = 1'b0;
  endtask

  // Observe from the first post-accept cycle until rsp_valid (bounded).
  // rdy_at = strobe cycle (1-based) in which epb_rdy is presented; 0 = never.
  task automatic watch_txn(input int rdy_at, input logic [15:0] rd_val, input logic [1:0] exp_be_n);
    logic got;
    got = 1'b0;
    w_lat = 0; w_cs_low = 0; w_oe_low = 0; w_doe_low = 0; w_rw0 = 0; w_be_match = 0; w_viol = 0;
    w_rdata = '0; w_to = 1'b0;
    for (int i = 1; i <= 60 && !got; i++) begin
      if (!bus.epb_cs_n) w_cs_low++;
      if (!bus.epb_oe_n) w_oe_low++;
      if (!bus.epb_data_oe_n) w_doe_low++;
      if (!bus.epb_r_w_n) w_rw0++;
      if (bus.epb_be_n == exp_be_n) w_be_match++;
      if (!bus.epb_data_oe_n && bus.epb_r_w_n) w_viol++;
      if (!bus.epb_oe_n && !(!bus.epb_cs_n && bus.epb_r_w_n)) w_viol++;
      if (bus.state_dbg == 3'd0 && !bus.epb_cs_n) w_viol++;
      if (bus.rsp_valid) begin
        got = 1'b1;
        w_lat = i;
        w_rdata = bus.rsp_rdata;
        w_to = bus.rsp_timeout;
      end else begin
        bus.epb_rdy = (!bus.epb_cs_n && w_cs_low == rdy_at);
        bus.epb_data_in = bus.epb_rdy ? rd_val : 16'hA5A5;
        step();
      end
    end
    bus.epb_rdy = 1'b0;
    bus.epb_data_in = 16'hA5A5;
    chk("rsp_seen", {31'd0, got}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec = 0; n_fail = 0; cs_high_run = 0; last_gap = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_addr_gp = '0;
    bus.req_be = '0; bus.req_wdata = '0; bus.epb_data_in = 16'hA5A5; bus.epb_rdy = 1'b0;
    step(); step();

    // reset values
    chk("rst_cs_n",      {31'd0, bus.epb_cs_n}, 32'd1);
    chk("rst_oe_n",      {31'd0, bus.epb_oe_n}, 32'd1);
    chk("rst_r_w_n",     {31'd0, bus.epb_r_w_n}, 32'd1);
    chk("rst_be_n",      {30'd0, bus.epb_be_n}, 32'd3);
    chk("rst_addr",      {9'd0, bus.epb_addr}, 32'd0);
    chk("rst_data_oe_n", {31'd0, bus.epb_data_oe_n}, 32'd1);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    // 1: write 0x000123 = 0xBEEF, rdy in first strobe cycle
    issue(1'b1, 23'h000123, 6'h00, 2'b11, 16'hBEEF, 1'b0);
    chk("wr_setup_addr",   {9'd0, bus.epb_addr}, 32'h123);
    chk("wr_setup_dout",   {16'd0, bus.epb_data_out}, 32'hBEEF);
    chk("wr_setup_cs_n",   {31'd0, bus.epb_cs_n}, 32'd1);
    chk("wr_setup_ready",  {31'd0, bus.req_ready}, 32'd0);
    watch_txn(1, 16'h0000, 2'b00);
    chk("wr_latency",  w_lat, 4);
    chk("wr_cs_low",   w_cs_low, 1);
    chk("wr_doe_low",  w_doe_low, 3);
    chk("wr_rw0",      w_rw0, 3);
    chk("wr_oe_low",   w_oe_low, 0);
    chk("wr_viol",     w_viol, 0);
    chk("wr_rdata",    {16'd0, w_rdata}, 32'd0);
    chk("wr_timeout",  {31'd0, w_to}, 32'd0);
    chk("wr_resp_be_n", {30'd0, bus.epb_be_n}, 32'd3);
    chk("wr_resp_addr", {9'd0, bus.epb_addr}, 32'h123);
    step();
    chk("wr_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);
    chk("wr_ready_back", {31'd0, bus.req_ready}, 32'd1);

    // 2: read 0x7FFFFF gp 0x3F, rdy on 6th strobe cycle with 0x1234
    issue(1'b0, 23'h7FFFFF, 6'h3F, 2'b11, 16'h0000, 1'b0);
    chk("rd_addr",    {9'd0, bus.epb_addr}, 32'h7FFFFF);
    chk("rd_addr_gp", {26'd0, bus.epb_addr_gp}, 32'h3F);
    watch_txn(6, 16'h1234, 2'b00);
    chk("rd_latency", w_lat, 9);
    chk("rd_oe_low",  w_oe_low, 6);
    chk("rd_cs_low",  w_cs_low, 6);
    chk("rd_doe_low", w_doe_low, 0);
    chk("rd_viol",    w_viol, 0);
    chk("rd_rdata",   {16'd0, w_rdata}, 32'h1234);
    chk("rd_timeout", {31'd0, w_to}, 32'd0);
    step();

    // 3: read with rdy never asserted -> timeout after 8 strobe cycles
    issue(1'b0, 23'h000456, 6'h01, 2'b11, 16'h0000, 1'b0);
    watch_txn(0, 16'hFFFF, 2'b00);
    chk("to_cs_low",  w_cs_low, 8);
    chk("to_latency", w_lat, 11);
    chk("to_flag",    {31'd0, w_to}, 32'd1);
    chk("to_rdata",   {16'd0, w_rdata}, 32'd0);
    chk("to_viol",    w_viol, 0);
    step();

    // 4: byte-lane write be=01
    chk("idle_be_n", {30'd0, bus.epb_be_n}, 32'd3);
    issue(1'b1, 23'h000010, 6'h00, 2'b01, 16'h00C3, 1'b0);
    chk("bl_setup_be_n", {30'd0, bus.epb_be_n}, 32'd2);
    watch_txn(2, 16'h0000, 2'b10);
    chk("bl_be_match", w_be_match, 4);
    chk("bl_latency",  w_lat, 5);
    chk("bl_resp_be_n", {30'd0, bus.epb_be_n}, 32'd3);
    step();

    // 5: back-to-back with req_valid held high
    issue(1'b1, 23'h000200, 6'h00, 2'b11, 16'h5A5A, 1'b1);
    bus.req_wr = 1'b0; bus.req_addr = 23'h000300;
    watch_txn(1, 16'h0000, 2'b00);
    chk("b2b_first_lat", w_lat, 4);
    chk("b2b_resp_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    chk("b2b_ready_next", {31'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk("b2b_second_addr", {9'd0, bus.epb_addr}, 32'h300);
    chk("b2b_second_rw",   {31'd0, bus.epb_r_w_n}, 32'd1);
    watch_txn(1, 16'h0BAD, 2'b00);
    chk("b2b_second_rdata", {16'd0, w_rdata}, 32'h0BAD);
    chk("b2b_cs_gap", last_gap, 4);
    step();

    // 6: reset pulse during STROBE of a write
    issue(1'b1, 23'h000777, 6'h00, 2'b11, 16'h1111, 1'b0);
    step();
    chk("rstmid_in_strobe", {31'd0, bus.epb_cs_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_cs_n",      {31'd0, bus.epb_cs_n}, 32'd1);
    chk("rstmid_data_oe_n", {31'd0, bus.epb_data_oe_n}, 32'd1);
    chk("rstmid_r_w_n",     {31'd0, bus.epb_r_w_n}, 32'd1);
    step();
    chk("rstmid_no_rsp_a", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("rstmid_no_rsp_b", {31'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    issue(1'b0, 23'h000042, 6'h02, 2'b11, 16'h0000, 1'b0);
    watch_txn(1, 16'h0F0F, 2'b00);
    chk("post_rst_lat",   w_lat, 4);
    chk("post_rst_rdata", {16'd0, w_rdata}, 32'h0F0F);
    chk("post_rst_to",    {31'd0, w_to}, 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/epb_master.md
Name: epb_master

Overview:
- Initiator end of the EPB (external peripheral bus) that the FPGA-side EPB slave infrastructure responds to.
- Turns a single-outstanding request/response interface into EPB read/write cycles: address/strobe sequencing, data-bus direction control, rdy wait and timeout.
- Used as the bus driver in system-level benches and as a bridge from an on-chip controller onto the EPB.

Parameters:
- SETUP_CYCLES, 1, cycles address/be/r_w_n are stable before epb_cs_n asserts (1..15)
- HOLD_CYCLES, 1, cycles address/data are held after epb_cs_n deasserts (1..15)
- TIMEOUT_CYCLES, 255, maximum cycles to wait for epb_rdy after strobe (1..65535)

Ports:
- epb_clk  in  1  bus clock; all logic on rising edge
- epb_rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  23  word address
- req_addr_gp  in  6  general-purpose address bits
- req_be  in  2  byte enables, active-high
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  16  read data; 0 for writes and timeouts
- rsp_timeout  out  1  qualifies rsp_valid: transaction timed out
- epb_cs_n  out  1  chip select, active-low
- epb_oe_n  out  1  output enable (read strobe), active-low
- epb_r_w_n  out  1  1 = read, 0 = write
- epb_be_n  out  2  byte enables, active-low
- epb_addr  out  23  address
- epb_addr_gp  out  6  GP address
- epb_data_out  out  16  write data to bus
- epb_data_oe_n  out  1  0 = master drives data bus
- epb_data_in  in  16  read data from bus
- epb_rdy  in  1  slave ready, active-high, sampled synchronously

Behaviour:
- Reset values (async on epb_rst_n low): epb_cs_n=1, epb_oe_n=1, epb_r_w_n=1, epb_be_n=2'b11, epb_addr=0, epb_addr_gp=0, epb_data_out=0, epb_data_oe_n=1, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, state=IDLE. req_ready rises on the first clock after reset release.
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE: req_ready=1. On accept, register addr, addr_gp, be, wr and wdata. Drive epb_addr, epb_addr_gp, epb_be_n=~req_be and epb_r_w_n=~req_wr. For writes, also drive epb_data_out and epb_data_oe_n=0. Load the setup counter with SETUP_CYCLES-1 and go to SETUP. req_ready=0 in every other state, so only one transaction is outstanding.
- SETUP: count down; at 0, set epb_cs_n=0 (and epb_oe_n=0 for reads), load the timeout counter with TIMEOUT_CYCLES and go to STROBE.
- STROBE: sample epb_rdy each cycle.
  - epb_rdy=1: latch epb_data_in into the read-data register (reads only), set epb_cs_n=1 and epb_oe_n=1, load the hold counter with HOLD_CYCLES-1, go to HOLD.
  - Otherwise decrement the timeout counter. If it reaches 0 with epb_rdy still 0, terminate the same way with the timeout flag set.
  - epb_rdy is never sampled in any state other than STROBE.
- Latency: minimum acceptance-to-rsp_valid = SETUP_CYCLES + 1 (rdy in first STROBE cycle) + HOLD_CYCLES + 1. With defaults and rdy immediate, that is 4 cycles.
- Timeout case: epb_cs_n stays low for exactly TIMEOUT_CYCLES cycles.
- HOLD: address, be_n, r_w_n and write data stay stable; epb_data_oe_n stays 0 for writes. At count 0: epb_data_oe_n=1, epb_r_w_n=1, epb_be_n=2'b11, go to RESP. Address outputs keep their last value.
- RESP: rsp_valid=1 for exactly one cycle. rsp_rdata is the latched data for a successful read, else 0. rsp_timeout=1 only on timeout. Return to IDLE; req_ready=1 in the next cycle. No back-pressure on the response.
- Bus invariants:
  - epb_data_oe_n=0 never coincides with epb_r_w_n=1.
  - epb_oe_n=0 only while epb_cs_n=0 and epb_r_w_n=1.
  - epb_cs_n is never low in IDLE.
- Counters are 16 bits. Out-of-range parameter values are unsupported; an elaboration-time check flags them.
- Reset mid-transaction: all outputs go immediately to their reset values (bus released, no rsp_valid). The aborted request is not reported.
- req_valid while not ready: ignored. The requester holds its request stable until accepted.

Test Plan:
- Write addr=0x000123, be=2'b11, wdata=0xBEEF, slave rdy on first STROBE cycle:
  - epb_r_w_n=0, epb_data_oe_n=0 from SETUP through HOLD; epb_cs_n low 1 cycle.
  - rsp_valid 4 cycles after accept; rsp_rdata=0, rsp_timeout=0.
- Read addr=0x7FFFFF, addr_gp=6'h3F, slave returns 0x1234 with rdy after 5 STROBE cycles:
  - epb_oe_n low 6 cycles, epb_data_oe_n stays 1.
  - rsp_rdata=0x1234 on the rsp_valid cycle.
- Read with rdy never asserted, TIMEOUT_CYCLES=8: epb_cs_n low exactly 8 cycles, then rsp_valid with rsp_timeout=1 and rsp_rdata=0.
- Byte-lane write, be=2'b01: epb_be_n=2'b10 throughout SETUP..HOLD, and 2'b11 in IDLE.
- Back-to-back requests with req_valid held high:
  - Second accept occurs the cycle after RESP.
  - epb_cs_n returns high for at least HOLD_CYCLES+SETUP_CYCLES+2 cycles between strobes.
- epb_rst_n pulsed low during STROBE of a write: epb_cs_n, epb_data_oe_n and epb_r_w_n go to 1 asynchronously, no rsp_valid, and a new request completes normally after release.
